// File: rtl/line_window_reader.sv
// line_window_reader: 3x3 sliding window over a raster pixel stream,
// two circular line memories. Optional LINE_WINDOW_COUNT_EN: window_count.
module line_window_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [9*DATA_WIDTH-1:0] out_window,
`ifdef LINE_WINDOW_COUNT_EN
  output logic [15:0]             window_count,
`endif
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_WIDTH-1:0] line0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  col_last, row_last;

  assign accept   = enable & in_valid;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Next raster position, next window and the flags this accept produces
  always_comb begin
    col_d = col_last ? '0 : col_q + 1'b1;
    row_d = row_q;
    if (col_last)
      row_d = row_last ? '0 : row_q + 1'b1;
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win_q[3*r+1];
      win_d[3*r+1] = win_q[3*r+2];
    end
    win_d[2] = line1_q[col_q];
    win_d[5] = line0_q[col_q];
    win_d[8] = in_data;
    valid_d  = in_valid & (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    done_d   = in_valid & col_last & row_last;
  end

  // Line memories: read-before-write, never cleared
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      line1_q[col_q] <= line0_q[col_q];
      line0_q[col_q] <= in_data;
    end
  end

  // Counters, window and output flags; everything freezes with enable low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '{default: '0};
    end else if (enable) begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        win_q <= win_d;
      end
    end
  end

  // Pack window registers, element 0 in the low bits
  always_comb begin
    out_window = '0;
    for (int k = 0; k < 9; k++)
      out_window[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
  end

  assign out_valid  = valid_q;
  assign frame_done = done_q;

`ifdef LINE_WINDOW_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Per-frame emission count; restarts once frame_done has been seen
  always_comb begin
    cnt_d = cnt_q + {15'd0, valid_d};
    if (done_q)
      cnt_d = '0;
  end

  // Count register, frozen with the rest of the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (enable)
      cnt_q <= cnt_d;
  end

  assign window_count = cnt_q;
`endif

endmodule

// File: tb/tb_line_window_reader.sv
// tb_line_window_reader: randomized and directed stimulus against
// a frame-image reference model (W=H=4).
module tb_line_window_reader;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [71:0]   out_window;
  logic          frame_done;
`ifdef LINE_WINDOW_COUNT_EN
  logic [15:0]   window_count;
  int            e_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int            idx;
  logic [DW-1:0] img [H][W];
  logic          e_valid;
  logic          e_done;
  logic [71:0]   e_win;
  int            dut_nwin;

  line_window_reader #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_window  (out_window),
`ifdef LINE_WINDOW_COUNT_EN
    .window_count(window_count),
`endif
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(int a0, int a1, int a2,
                                        int a3, int a4, int a5,
                                        int a6, int a7, int a8);
    int v [9];
    logic [71:0] p;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    p = '0;
    for (int k = 0; k < 9; k++)
      p[k*8 +: 8] = v[k][7:0];
    return p;
  endfunction

  // Called at posedge+1; drives one cycle and checks its outcome
  task automatic step(bit en, bit v, logic [DW-1:0] d);
    int r;
    int c;
    enable   = en;
    in_valid = v;
    in_data  = d;
    if (en) begin
      r = idx / W;
      c = idx % W;
`ifdef LINE_WINDOW_COUNT_EN
      if (e_done)
        e_cnt = 0;
      else if (v && r >= 2 && c >= 2)
        e_cnt++;
`endif
      if (!v) begin
        e_valid = 1'b0;
        e_done  = 1'b0;
      end else begin
        img[r][c] = d;
        e_valid = (r >= 2) && (c >= 2);
        if (e_valid)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e_win[(3*i+j)*8 +: 8] = img[r-2+i][c-2+j];
        e_done = (idx == W*H-1);
        idx = (idx + 1) % (W*H);
      end
    end
    @(posedge clk);
    #1;
    if (out_valid && en)
      dut_nwin++;
    chk("out_valid", 72'(out_valid), 72'(e_valid));
    chk("frame_done", 72'(frame_done), 72'(e_done));
    if (e_valid)
      chk("window", out_window, e_win);
`ifdef LINE_WINDOW_COUNT_EN
    chk("window_count", 72'(window_count), 72'(e_cnt));
`endif
  endtask

  // Asynchronous reset applied between clock edges
  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    chk("rst_valid", 72'(out_valid), 72'(0));
    chk("rst_done", 72'(frame_done), 72'(0));
    chk("rst_window", out_window, 72'(0));
`ifdef LINE_WINDOW_COUNT_EN
    chk("rst_count", 72'(window_count), 72'(0));
    e_cnt = 0;
`endif
    idx     = 0;
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_win   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [71:0] first;
    logic [71:0] first2;
    first  = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    first2 = pack9(100, 101, 102, 104, 105, 106, 108, 109, 110);
    reset = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    dut_nwin = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (i == 10) chk("first_win", out_window, first);
    end
    chk("nwin_frame", 72'(dut_nwin), 72'(4));

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(i));
      step(1'b1, 1'b0, 8'($urandom));
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (i == 10)
        repeat (3) begin
          step(1'b0, 1'($urandom), 8'($urandom));
          chk("stall_win", out_window, first);
        end
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(100 + i));
      if (i == 10) chk("frame2_win", out_window, first2);
    end

    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 8'(i));
    do_reset();
    dut_nwin = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (i == 10) chk("rst_first_win", out_window, first);
    end
    chk("nwin_after_rst", 72'(dut_nwin), 72'(4));

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_reader.md
Name: line_window_reader

Overview:
- Consumer end of the pixel delay path. Accepts a raster-ordered pixel stream and buffers the two previous image lines in circular line memories.
- Emits a 3x3 convolution window each time a fully populated window is available.
- Sits between the input pixel stream and the CNN convolution MAC array, replacing long register-chain line delays with pointer-addressed storage.

Parameters:
- DATA_WIDTH, 8, bits per pixel
- IMG_WIDTH, 28, pixels per line (line memory depth); minimum 3
- IMG_HEIGHT, 28, lines per frame; minimum 3

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  global stall; low freezes all state
- in_valid  input  1  in_data is valid this cycle
- in_data  input  DATA_WIDTH  pixel, raster order
- out_valid  output  1  out_window holds a valid window
- out_window  output  9*DATA_WIDTH  window; element k = 3*r+c at [k*DATA_WIDTH +: DATA_WIDTH]; r=0 top (oldest) row, c=0 left (oldest) column; element 8 = newest pixel
- frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, active-high):
  - col, row counters = 0
  - 3x3 window registers = 0
  - out_valid = 0, out_window = 0, frame_done = 0
  - line memory contents undefined and not cleared
- Accept condition: enable && in_valid. Nothing changes on non-accept cycles except out_valid/frame_done handling below.
- On accept, at address col:
  - line1[col] <= line0[col]
  - line0[col] <= in_data
  - Window rows shift left one column; new right column = {line1[col] (top), line0[col] (mid), in_data (bottom)}
  - Memory reads use pre-write values (read-before-write)
- Counters:
  - col increments per accept.
  - At col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row == IMG_HEIGHT-1 && col == IMG_WIDTH-1, both wrap to 0.
- out_valid: registered. Set 1 the cycle after an accept with row >= 2 && col >= 2 (pre-increment values); 0 after any other accept. Latency: 1 clock from accepting pixel to its window.
- Windows spanning a line wrap (col < 2) are never valid.
- Count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows per frame.
- frame_done: 1 for exactly the cycle after the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); else 0.
- enable low:
  - Counters, memories, window, out_valid, out_window and frame_done all hold.
  - A held out_valid=1 must not be counted twice downstream; consumer qualifies with enable.
- enable high, in_valid low: out_valid and frame_done clear to 0; everything else holds.
- Gaps in in_valid are allowed anywhere, including across line and frame boundaries; the window result is identical to gapless streaming.
- Back-to-back frames need no idle cycle; the first two lines of the new frame are re-primed, and stale memory data is never exposed as valid.
- Reset mid-frame: immediate return to reset state; the next accepted pixel is treated as (0,0).

Optional Feature:
- Macro: LINE_WINDOW_COUNT_EN
- Defined:
  - Adds output port window_count, 16 bits, reset 0.
  - Increments with every out_valid rise-qualified emission (each accept producing a valid window).
  - Clears to 0 on the cycle frame_done is asserted; the final value is sampled on that same cycle.
- Undefined: port and counter absent; all other behaviour unchanged.

Test Plan:
- W=H=4, stream 0..15 gapless, enable=1 -> out_valid only the cycle after pixels 10, 11, 14, 15. First window = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}; frame_done the cycle after pixel 15.
- Same stream with in_valid low every other cycle -> identical windows in identical order; out_valid never high on cycles following an idle input.
- Same stream with enable low for 3 cycles right after pixel 10 -> out_valid and window {0,1,2,4,5,6,8,9,10} held 3 extra cycles; no pixel lost; subsequent windows correct.
- Two frames back-to-back, frame 2 pixels = 100+i -> frame 2's first window is {100,101,102,104,105,106,108,109,110}; no valid output during frame 2 rows 0-1.
- Assert reset after pixel 9, then stream 0..15 -> no out_valid before the new pixel 10; windows match the first scenario.
- LINE_WINDOW_COUNT_EN, W=H=4 -> window_count reads 4 on the frame_done cycle, then 0.
